// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, sync pulses, data enable,
// frame/line markers and a frame counter, all registered and aligned to one pixel position.
module vga_timing_gen #(
    parameter int   H_ACTIVE  = 1280,
    parameter int   H_FP      = 48,
    parameter int   H_SYNC    = 112,
    parameter int   H_BP      = 248,
    parameter int   V_ACTIVE  = 1024,
    parameter int   V_FP      = 1,
    parameter int   V_SYNC    = 3,
    parameter int   V_BP      = 38,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1,
    parameter int   CTR_W     = 11,
    parameter int   FRAME_W   = 8
) (
    input  logic               CLK_108MHz,
    input  logic               reset_n,
    input  logic               en,
    output logic [CTR_W-1:0]   hctr,
    output logic [CTR_W-1:0]   vctr,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               sof,
    output logic               eol,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CTR_W-1:0]   CTR_ZERO  = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0]   CTR_ONE   = CTR_W'(1);
    localparam logic [CTR_W-1:0]   H_LAST    = CTR_W'(H_TOTAL - 1);
    localparam logic [CTR_W-1:0]   V_LAST    = CTR_W'(V_TOTAL - 1);
    localparam logic [CTR_W-1:0]   H_ACT_END = CTR_W'(H_ACTIVE);
    localparam logic [CTR_W-1:0]   V_ACT_END = CTR_W'(V_ACTIVE);
    localparam logic [CTR_W-1:0]   HS_START  = CTR_W'(H_ACTIVE + H_FP);
    localparam logic [CTR_W-1:0]   HS_END    = CTR_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CTR_W-1:0]   VS_START  = CTR_W'(V_ACTIVE + V_FP);
    localparam logic [CTR_W-1:0]   VS_END    = CTR_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

    logic [CTR_W-1:0] h_int_r;
    logic [CTR_W-1:0] v_int_r;
    logic [CTR_W-1:0] h_next_s;
    logic [CTR_W-1:0] v_next_s;
    logic             h_last_s;
    logic             v_last_s;
    logic             de_s;
    logic             hs_act_s;
    logic             vs_act_s;
    logic             sof_s;

    // Next raster position and decode of the current one
    always_comb begin
        h_last_s = (h_int_r == H_LAST);
        v_last_s = (v_int_r == V_LAST);
        if (h_last_s) begin
            h_next_s = CTR_ZERO;
            if (v_last_s) begin
                v_next_s = CTR_ZERO;
            end else begin
                v_next_s = v_int_r + CTR_ONE;
            end
        end else begin
            h_next_s = h_int_r + CTR_ONE;
            v_next_s = v_int_r;
        end
        de_s     = (h_int_r < H_ACT_END) && (v_int_r < V_ACT_END);
        hs_act_s = (h_int_r >= HS_START) && (h_int_r < HS_END);
        vs_act_s = (v_int_r >= VS_START) && (v_int_r < VS_END);
        sof_s    = (h_int_r == CTR_ZERO) && (v_int_r == CTR_ZERO);
    end

    // Internal scan position; stopping parks it at the origin so a restart begins a fresh frame
    always_ff @(posedge CLK_108MHz or negedge reset_n) begin
        if (!reset_n) begin
            h_int_r <= CTR_ZERO;
            v_int_r <= CTR_ZERO;
        end else if (!en) begin
            h_int_r <= CTR_ZERO;
            v_int_r <= CTR_ZERO;
        end else begin
            h_int_r <= h_next_s;
            v_int_r <= v_next_s;
        end
    end

    // Registered outputs; frame_cnt survives a stop so software sees a monotonic count
    always_ff @(posedge CLK_108MHz or negedge reset_n) begin
        if (!reset_n) begin
            hctr      <= CTR_ZERO;
            vctr      <= CTR_ZERO;
            hsync     <= ~HSYNC_POL;
            vsync     <= ~VSYNC_POL;
            de        <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            frame_cnt <= {FRAME_W{1'b0}};
        end else if (!en) begin
            hctr      <= CTR_ZERO;
            vctr      <= CTR_ZERO;
            hsync     <= ~HSYNC_POL;
            vsync     <= ~VSYNC_POL;
            de        <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            frame_cnt <= frame_cnt;
        end else begin
            hctr      <= h_int_r;
            vctr      <= v_int_r;
            hsync     <= hs_act_s ? HSYNC_POL : ~HSYNC_POL;
            vsync     <= vs_act_s ? VSYNC_POL : ~VSYNC_POL;
            de        <= de_s;
            sof       <= sof_s;
            eol       <= h_last_s;
            frame_cnt <= sof_s ? (frame_cnt + FRAME_ONE) : frame_cnt;
        end
    end

endmodule
